stream_fanout_buf: RTL and testbench



---
 rtl/stream_fanout_buf.sv | 135 +++++++++++++
 tb/tb_stream_fanout_buf.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_fanout_buf.sv
// One-to-many valid/ready broadcast with an independent FIFO per consumer channel.
// Define STREAM_FANOUT_STAT_EN to add the stat_words / stat_stall counters.
module stream_fanout_buf #(
  parameter int DWIDTH = 16,
  parameter int CH_NUM = 2,
  parameter int DEPTH  = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 cfg_valid,
  output logic                                 cfg_busy,
  input  logic [CH_NUM-1:0]                    cfg_mask,
  input  logic                                 din_valid,
  output logic                                 din_ready,
  input  logic [DWIDTH-1:0]                    din_data,
  output logic [CH_NUM-1:0]                    dout_valid,
  input  logic [CH_NUM-1:0]                    dout_ready,
  output logic [DWIDTH*CH_NUM-1:0]             dout_data,
  output logic [($clog2(DEPTH)+1)*CH_NUM-1:0]  ch_level
`ifdef STREAM_FANOUT_STAT_EN
  ,
  output logic [31:0]                          stat_words,
  output logic [31:0]                          stat_stall
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  logic [0:0]        state_reg;
  logic [CH_NUM-1:0] mask_reg;
  logic [CH_NUM-1:0] pend_reg;
  logic [CH_NUM-1:0] full;
  logic [CH_NUM-1:0] not_empty;
  logic              accept;

  // Disabled channels may sit full forever without back-pressuring the source.
  assign din_ready = (state_reg == ST_RUN) && ((full & mask_reg) == '0);
  assign accept    = din_valid && din_ready;
  assign cfg_busy  = (state_reg == ST_DRAIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_RUN;
      mask_reg  <= '1;
      pend_reg  <= '1;
    end else begin
      case (state_reg)
        ST_RUN: begin
          if (cfg_valid) begin
            pend_reg  <= cfg_mask;
            state_reg <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (not_empty == '0) begin
            mask_reg  <= pend_reg;
            state_reg <= ST_RUN;
          end
        end
        default: state_reg <= ST_RUN;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CH_NUM; gi++) begin : g_ch
      logic [DWIDTH-1:0] mem [DEPTH];
      logic [PTR_W-1:0]  wr_ptr_reg;
      logic [PTR_W-1:0]  rd_ptr_reg;
      logic [LVL_W-1:0]  level_reg;
      logic              push;
      logic              pop;

      assign push = accept && mask_reg[gi];
      assign pop  = (level_reg != '0) && dout_ready[gi];

      // Storage carries no reset; validity is tracked by level_reg alone.
      always_ff @(posedge clk) begin
        if (push) begin
          mem[wr_ptr_reg] <= din_data;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          level_reg  <= '0;
        end else begin
          if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
          end
          if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
          end
          level_reg <= level_reg + LVL_W'(push) - LVL_W'(pop);
        end
      end

      assign full[gi]       = (level_reg == LVL_W'(DEPTH));
      assign not_empty[gi]  = (level_reg != '0);
      assign dout_valid[gi] = not_empty[gi];
      assign dout_data[gi*DWIDTH +: DWIDTH] = mem[rd_ptr_reg];
      assign ch_level[gi*LVL_W +: LVL_W]    = level_reg;
    end
  endgenerate

`ifdef STREAM_FANOUT_STAT_EN
  logic [31:0] stat_words_reg;
  logic [31:0] stat_stall_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_words_reg <= '0;
      stat_stall_reg <= '0;
    end else begin
      if (accept) begin
        stat_words_reg <= stat_words_reg + 32'd1;
      end
      if (din_valid && !din_ready) begin
        stat_stall_reg <= stat_stall_reg + 32'd1;
      end
    end
  end

  assign stat_words = stat_words_reg;
  assign stat_stall = stat_stall_reg;
`endif

endmodule

// File: tb/tb_stream_fanout_buf.sv
// Scoreboard bench for stream_fanout_buf (CH_NUM=2, DEPTH=4, DWIDTH=16).
module tb_stream_fanout_buf;
  localparam int DW    = 16;
  localparam int CH    = 2;
  localparam int DEPTH = 4;
  localparam int LW    = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              cfg_busy;
  logic [CH-1:0]     cfg_mask = '0;
  logic              din_valid = 1'b0;
  logic              din_ready;
  logic [DW-1:0]     din_data = '0;
  logic [CH-1:0]     dout_valid;
  logic [CH-1:0]     dout_ready = '0;
  logic [DW*CH-1:0]  dout_data;
  logic [LW*CH-1:0]  ch_level;
`ifdef STREAM_FANOUT_STAT_EN
  logic [31:0]       stat_words;
  logic [31:0]       stat_stall;
`endif

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic [CH-1:0] model_mask = 2'b11;

  stream_fanout_buf #(.DWIDTH(DW), .CH_NUM(CH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_busy(cfg_busy), .cfg_mask(cfg_mask),
    .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
    .ch_level(ch_level)
`ifdef STREAM_FANOUT_STAT_EN
    , .stat_words(stat_words), .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  // Scoreboard: push on source handshake, pop/compare on each consumer handshake.
  always @(negedge clk) begin
    logic [DW-1:0] exp_w;
    if (rst_n) begin
      if (din_valid && din_ready) begin
        if (model_mask[0]) q0.push_back(din_data);
        if (model_mask[1]) q1.push_back(din_data);
      end
      if (dout_valid[0] && dout_ready[0]) begin
        tests++;
        if (q0.size() == 0) begin
          fails++;
          $display("FAIL sb_ch0: got %h, required no word", dout_data[15:0]);
        end else begin
          exp_w = q0.pop_front();
          if (dout_data[15:0] !== exp_w) begin
            fails++;
            $display("FAIL sb_ch0: got %h, required %h", dout_data[15:0], exp_w);
          end
        end
      end
      if (dout_valid[1] && dout_ready[1]) begin
        tests++;
        if (q1.size() == 0) begin
          fails++;
          $display("FAIL sb_ch1: got %h, required no word", dout_data[31:16]);
        end else begin
          exp_w = q1.pop_front();
          if (dout_data[31:16] !== exp_w) begin
            fails++;
            $display("FAIL sb_ch1: got %h, required %h", dout_data[31:16], exp_w);
          end
        end
      end
    end
  end

  task automatic send(input logic [DW-1:0] d, output bit ok);
    din_valid = 1'b1;
    din_data  = d;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (din_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    din_valid = 1'b0;
    $display("[TB] send %h accepted=%0d", d, ok);
  endtask

  task automatic pulse_cfg(input logic [CH-1:0] m);
    cfg_valid = 1'b1;
    cfg_mask  = m;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (q0.size() == 0 && q1.size() == 0 && dout_valid == '0 && !cfg_busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #3;
    tests++;
    if (dout_valid !== 2'b00 || cfg_busy !== 1'b0 || din_ready !== 1'b1 || ch_level !== '0) begin
      fails++;
      $display("FAIL reset_state: valid=%b busy=%b ready=%b level=%h, required 00 0 1 0",
               dout_valid, cfg_busy, din_ready, ch_level);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    $display("[TB] reset released");
  endtask

  task automatic test_broadcast();
    bit ok;
    dout_ready = 2'b11;
    din_valid  = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      din_data = DW'(i);
      if (i == 9) din_valid = 1'b0;
      @(negedge clk);
      if (i > 1) begin
        tests++;
        if (dout_valid !== 2'b11 || dout_data !== {DW'(i - 1), DW'(i - 1)}) begin
          fails++;
          $display("FAIL bcast_latency word %0d: valid=%b data=%h, required 11 %h%h",
                   i - 1, dout_valid, dout_data, DW'(i - 1), DW'(i - 1));
        end
      end
      if (i < 9) begin
        tests++;
        if (din_ready !== 1'b1) begin
          fails++;
          $display("FAIL bcast_ready word %0d: din_ready=%b, required 1", i, din_ready);
        end
      end
      @(posedge clk); #1;
    end
    wait_idle(ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL bcast_drain: queues %0d/%0d left, required 0/0", q0.size(), q1.size());
    end
  endtask

  task automatic test_stall();
    bit ok;
    dout_ready = 2'b01;
    for (int i = 1; i <= 4; i++) begin
      send(DW'(16'h0100 + i), ok);
      tests++;
      if (!ok) begin
        fails++;
        $display("FAIL stall_send %0d: accepted=0, required 1", i);
      end
    end
    din_valid = 1'b1;
    din_data  = 16'h0105;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++;
      if (ch_level[5:3] !== 3'd4 || din_ready !== 1'b0) begin
        fails++;
        $display("FAIL stall_full: level1=%0d din_ready=%b, required 4 0", ch_level[5:3], din_ready);
      end
      @(posedge clk); #1;
    end
    dout_ready = 2'b11;
    send(16'h0105, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL stall_w5: accepted=0, required 1"); end
    send(16'h0106, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL stall_w6: accepted=0, required 1"); end
    wait_idle(ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL stall_drain: queues %0d/%0d left, required 0/0", q0.size(), q1.size());
    end
  endtask

  task automatic test_mask_change();
    bit ok;
    dout_ready = 2'b01;
    for (int i = 1; i <= 3; i++) send(DW'(16'h0200 + i), ok);
    pulse_cfg(2'b01);
    @(negedge clk);
    tests++;
    if (cfg_busy !== 1'b1 || din_ready !== 1'b0) begin
      fails++;
      $display("FAIL mask_busy: busy=%b din_ready=%b, required 1 0", cfg_busy, din_ready);
    end
    @(posedge clk); #1;
    pulse_cfg(2'b10);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++;
      if (cfg_busy !== 1'b1 || ch_level[5:3] !== 3'd3) begin
        fails++;
        $display("FAIL mask_hold: busy=%b level1=%0d, required 1 3", cfg_busy, ch_level[5:3]);
      end
      @(posedge clk); #1;
    end
    dout_ready = 2'b11;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (!cfg_busy) begin ok = 1'b1; break; end
    end
    tests++;
    if (!ok || ch_level !== '0) begin
      fails++;
      $display("FAIL mask_exit: busy_fell=%0d level=%h, required 1 0", ok, ch_level);
    end
    @(posedge clk); #1;
    model_mask = 2'b01;
    send(16'h00AA, ok);
    @(negedge clk);
    tests++;
    if (dout_valid !== 2'b01 || dout_data[15:0] !== 16'h00AA) begin
      fails++;
      $display("FAIL mask_apply: valid=%b data0=%h, required 01 00aa", dout_valid, dout_data[15:0]);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++;
      if (dout_valid[1] !== 1'b0) begin
        fails++;
        $display("FAIL mask_ch1_quiet: dout_valid[1]=%b, required 0", dout_valid[1]);
      end
    end
    wait_idle(ok);
  endtask

  task automatic test_sink();
    bit ok;
    pulse_cfg(2'b00);
    wait_idle(ok);
    model_mask = 2'b00;
    din_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      din_data = DW'(16'h0300 + i);
      @(negedge clk);
      tests++;
      if (din_ready !== 1'b1 || dout_valid !== 2'b00 || ch_level !== '0) begin
        fails++;
        $display("FAIL sink %0d: ready=%b valid=%b level=%h, required 1 00 0",
                 i, din_ready, dout_valid, ch_level);
      end
      @(posedge clk); #1;
    end
    din_valid = 1'b0;
    pulse_cfg(2'b11);
    wait_idle(ok);
    model_mask = 2'b11;
  endtask

  task automatic test_reset_mid();
    bit ok;
    dout_ready = 2'b00;
    send(16'h0401, ok);
    send(16'h0402, ok);
    pulse_cfg(2'b01);
    @(negedge clk);
    tests++;
    if (cfg_busy !== 1'b1 || ch_level !== 6'o22) begin
      fails++;
      $display("FAIL rmid_pre: busy=%b level=%o, required 1 22", cfg_busy, ch_level);
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    #1;
    tests++;
    if (dout_valid !== 2'b00 || cfg_busy !== 1'b0 || din_ready !== 1'b1 || ch_level !== '0) begin
      fails++;
      $display("FAIL rmid_async: valid=%b busy=%b ready=%b level=%h, required 00 0 1 0",
               dout_valid, cfg_busy, din_ready, ch_level);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_mask = 2'b11;
    dout_ready = 2'b11;
    send(16'hBEEF, ok);
    @(negedge clk);
    tests++;
    if (dout_valid !== 2'b11 || dout_data !== 32'hBEEF_BEEF) begin
      fails++;
      $display("FAIL rmid_after: valid=%b data=%h, required 11 beefbeef", dout_valid, dout_data);
    end
    wait_idle(ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL rmid_drain: queues %0d/%0d left, required 0/0", q0.size(), q1.size());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_broadcast();
    test_stall();
    test_mask_change();
    test_sink();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
